// File: rtl/hsid_pkg.sv
// Shared types and constants for the hyperspectral identification pipeline.
package hsid_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } hsid_min_state_t;

  // Widest accumulator the sentinel helper is able to describe.
  localparam int ACC_MAX_WIDTH = 128;

  // All-ones sentinel in the low 'width' bits; callers keep the slice they need.
  function automatic logic [ACC_MAX_WIDTH-1:0] acc_sentinel(input int width);
    logic [ACC_MAX_WIDTH-1:0] ones;
    ones = '0;
    for (int i = 0; i < ACC_MAX_WIDTH; i++) begin
      if (i < width) begin
        ones[i] = 1'b1;
      end
    end
    return ones;
  endfunction

endpackage

// File: rtl/hsid_min_dist.sv
// Best spectral match: tracks the smallest accumulated distance over one
// library sweep and reports it with its reference index and a done pulse.
module hsid_min_dist
  import hsid_pkg::*;
#(
  parameter  int DATA_WIDTH_ACC        = 48,
  parameter  int HSI_LIBRARY_SIZE      = 4095,
  localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] lib_size,
  input  logic                             acc_valid,
  input  logic [DATA_WIDTH_ACC-1:0]        acc_value,
  input  logic                             acc_last,
  input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] acc_ref,
  output logic                             busy,
  output logic                             done,
  output logic [DATA_WIDTH_ACC-1:0]        min_value,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] min_ref,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] refs_seen
);

  localparam logic [ACC_MAX_WIDTH-1:0] SENTINEL_WIDE = acc_sentinel(DATA_WIDTH_ACC);
  localparam logic [DATA_WIDTH_ACC-1:0] ACC_ONES = SENTINEL_WIDE[DATA_WIDTH_ACC-1:0];
  localparam logic [HSI_LIBRARY_SIZE_ADDR-1:0] ONE_REF = 1;

  hsid_min_state_t state;
  hsid_min_state_t next_state;

  logic [HSI_LIBRARY_SIZE_ADDR-1:0] target;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0] seen_inc;
  logic                             counted;
  logic                             take_min;

  // A beat counts only when it closes a reference during a search; a
  // coincident start takes priority and drops it.
  always_comb begin
    counted  = 1'b0;
    take_min = 1'b0;
    seen_inc = refs_seen + ONE_REF;
    if ((state == SEARCH) && acc_valid && acc_last && !start) begin
      counted = 1'b1;
    end
    if (counted && ((refs_seen == '0) || (acc_value < min_value))) begin
      take_min = 1'b1;
    end
  end

  // Next-state logic; start restarts the search from any state.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = (lib_size == '0) ? DONE : SEARCH;
    end else begin
      case (state)
        IDLE:    next_state = IDLE;
        SEARCH:  next_state = (counted && (seen_inc == target)) ? DONE : SEARCH;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // State, status flags and the running minimum, all registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      target    <= '0;
      min_value <= '0;
      min_ref   <= '0;
      refs_seen <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state == SEARCH);
      done  <= (next_state == DONE);
      if (start) begin
        target    <= lib_size;
        min_value <= ACC_ONES;
        min_ref   <= '0;
        refs_seen <= '0;
      end else if (counted) begin
        refs_seen <= seen_inc;
        if (take_min) begin
          min_value <= acc_value;
          min_ref   <= acc_ref;
        end
      end
    end
  end

endmodule
